// File: rtl/cpu_dmem_wb_if.sv
// Request/response and Wishbone D-bus signals for the Moxie data-memory port.
// The slave modport is the controller's view; master is the requester plus bus slave side.
interface cpu_dmem_wb_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        stall_o;
  logic [31:0] wb_D_adr_o;
  logic [31:0] wb_D_dat_o;
  logic [3:0]  wb_D_sel_o;
  logic        wb_D_we_o;
  logic        wb_D_cyc_o;
  logic        wb_D_stb_o;
  logic [31:0] wb_D_dat_i;
  logic        wb_D_ack_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, stall_o,
    output wb_D_adr_o, wb_D_dat_o, wb_D_sel_o, wb_D_we_o, wb_D_cyc_o, wb_D_stb_o,
    input  wb_D_dat_i, wb_D_ack_i
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, stall_o,
    input  wb_D_adr_o, wb_D_dat_o, wb_D_sel_o, wb_D_we_o, wb_D_cyc_o, wb_D_stb_o,
    output wb_D_dat_i, wb_D_ack_i
  );
endinterface

// File: rtl/cpu_dmem_wb.sv
// Moxie data-memory port: one load/store at a time as a single classic Wishbone
// cycle, with big-endian byte-lane steering, misalignment detection and ack timeout.
module cpu_dmem_wb #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk_i,
  input logic          rst_i,
  cpu_dmem_wb_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  tmo_cnt;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        cyc_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  logic        misaligned;
  logic [3:0]  sel_n;
  logic [31:0] dat_n;
  logic [31:0] ld_data;

  // Store steering: lane n carries address offset n, lane 0 being bits [31:24].
  always_comb begin
    misaligned = 1'b0;
    sel_n      = '0;
    dat_n      = '0;
    case (bus.req_size_i)
      2'b00: begin
        sel_n = 4'b1000 >> bus.req_addr_i[1:0];
        case (bus.req_addr_i[1:0])
          2'd0:    dat_n = {bus.req_data_i[7:0], 24'h0};
          2'd1:    dat_n = {8'h0, bus.req_data_i[7:0], 16'h0};
          2'd2:    dat_n = {16'h0, bus.req_data_i[7:0], 8'h0};
          default: dat_n = {24'h0, bus.req_data_i[7:0]};
        endcase
      end
      2'b01: begin
        misaligned = bus.req_addr_i[0];
        if (bus.req_addr_i[1]) begin
          sel_n = 4'b0011;
          dat_n = {16'h0, bus.req_data_i[15:0]};
        end else begin
          sel_n = 4'b1100;
          dat_n = {bus.req_data_i[15:0], 16'h0};
        end
      end
      2'b10: begin
        misaligned = |bus.req_addr_i[1:0];
        sel_n      = 4'b1111;
        dat_n      = bus.req_data_i;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    ld_data = {24'h0, bus.wb_D_dat_i[31:24]};
          2'd1:    ld_data = {24'h0, bus.wb_D_dat_i[23:16]};
          2'd2:    ld_data = {24'h0, bus.wb_D_dat_i[15:8]};
          default: ld_data = {24'h0, bus.wb_D_dat_i[7:0]};
        endcase
      end
      2'b01:   ld_data = off_q[1] ? {16'h0, bus.wb_D_dat_i[15:0]}
                                  : {16'h0, bus.wb_D_dat_i[31:16]};
      default: ld_data = bus.wb_D_dat_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      size_q     <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            if (misaligned) begin
              state      <= S_RESP;
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
            end else begin
              state   <= S_BUS;
              adr_q   <= {bus.req_addr_i[31:2], 2'b00};
              dat_q   <= dat_n;
              sel_q   <= sel_n;
              we_q    <= bus.req_we_i;
              size_q  <= bus.req_size_i;
              off_q   <= bus.req_addr_i[1:0];
              cyc_q   <= 1'b1;
              tmo_cnt <= '0;
            end
          end
        end
        S_BUS: begin
          // Ack is checked first so an ack on the final timeout cycle still completes normally.
          if (bus.wb_D_ack_i) begin
            state      <= S_RESP;
            cyc_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= we_q ? '0 : ld_data;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= S_RESP;
            cyc_q      <= 1'b0;
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          rsp_err_q  <= 1'b0;
          rsp_data_q <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (state == S_IDLE);
  assign bus.rsp_valid_o = (state == S_RESP);
  assign bus.stall_o     = (state == S_BUS) || (state == S_RESP);
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.wb_D_adr_o  = adr_q;
  assign bus.wb_D_dat_o  = dat_q;
  assign bus.wb_D_sel_o  = sel_q;
  assign bus.wb_D_we_o   = we_q;
  assign bus.wb_D_cyc_o  = cyc_q;
  assign bus.wb_D_stb_o  = cyc_q;

endmodule

// File: tb/tb_cpu_dmem_wb.sv
// Directed bench for cpu_dmem_wb: responses are checked against a scoreboard
// of expected {err, data} pushed as each request is issued.
module tb_cpu_dmem_wb;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] sb_q[$];

  cpu_dmem_wb_if bus ();

  cpu_dmem_wb #(.TIMEOUT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && bus.rsp_valid_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, e[32]});
        chk("rsp_data", bus.rsp_data_o, e[31:0]);
      end
    end
  end

  task automatic drive_req(input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_size_i  = size;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_data_i  = '0;
  endtask

  // Called #1 after a rising edge with the block idle. ack_after < 0 means never ack.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int ack_after, input logic [31:0] rd,
                         input logic exp_err, input logic [31:0] exp_data,
                         input logic [3:0] exp_sel, input logic [31:0] exp_dato,
                         input int exp_cyc);
    int cyc_cnt;
    bit done;
    chk({tag, "_ready"}, {31'h0, bus.req_ready_o}, 32'h1);
    drive_req(we, size, addr, data);
    sb_q.push_back({exp_err, exp_data});
    cyc_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!bus.wb_D_cyc_o) begin
        done = 1'b1;
      end else begin
        if (c == 0) begin
          chk({tag, "_adr"}, bus.wb_D_adr_o, {addr[31:2], 2'b00});
          chk({tag, "_sel"}, {28'h0, bus.wb_D_sel_o}, {28'h0, exp_sel});
          chk({tag, "_we"}, {31'h0, bus.wb_D_we_o}, {31'h0, we});
          chk({tag, "_dat_o"}, bus.wb_D_dat_o, exp_dato);
          chk({tag, "_stb"}, {31'h0, bus.wb_D_stb_o}, 32'h1);
          chk({tag, "_stall"}, {31'h0, bus.stall_o}, 32'h1);
        end
        cyc_cnt++;
        if (ack_after >= 0 && cyc_cnt == ack_after + 1) begin
          bus.wb_D_ack_i = 1'b1;
          bus.wb_D_dat_i = rd;
        end
        @(posedge clk_i);
        #1;
        bus.wb_D_ack_i = 1'b0;
        bus.wb_D_dat_i = 32'hFFFF_FFFF;
      end
    end
    chk({tag, "_bus_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_cyc_cycles"}, cyc_cnt, exp_cyc);
    chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid_o}, 32'h1);
    @(posedge clk_i);
    #1;
    chk({tag, "_rsp_pulse_end"}, {31'h0, bus.rsp_valid_o}, 32'h0);
    chk({tag, "_ready_again"}, {31'h0, bus.req_ready_o}, 32'h1);
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_size_i  = 2'b00;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.wb_D_ack_i  = 1'b0;
    bus.wb_D_dat_i  = 32'hFFFF_FFFF;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'h0, bus.req_ready_o}, 32'h1);
    chk("rst_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err_o}, 32'h0);
    chk("rst_rsp_data", bus.rsp_data_o, 32'h0);
    chk("rst_cyc_stb_we", {29'h0, bus.wb_D_cyc_o, bus.wb_D_stb_o, bus.wb_D_we_o}, 32'h0);
    chk("rst_sel", {28'h0, bus.wb_D_sel_o}, 32'h0);
    chk("rst_adr", bus.wb_D_adr_o, 32'h0);
    chk("rst_dat_o", bus.wb_D_dat_o, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    run_req("word_store", 1'b1, 2'b10, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0,
            1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1);
    // Ack lands on the last timeout cycle (TIMEOUT=4): must complete normally.
    run_req("byte_load", 1'b0, 2'b00, 32'h0000_2003, 32'h0, 3, 32'h1122_3344,
            1'b0, 32'h0000_0044, 4'b0001, 32'h0, 4);
    run_req("half_store", 1'b1, 2'b01, 32'h0000_3002, 32'h0000_ABCD, 1, 32'h0,
            1'b0, 32'h0, 4'b0011, 32'h0000_ABCD, 2);
    run_req("half_load", 1'b0, 2'b01, 32'h0000_3000, 32'h0, 0, 32'hABCD_1234,
            1'b0, 32'h0000_ABCD, 4'b1100, 32'h0, 1);
    run_req("byte_store1", 1'b1, 2'b00, 32'h0000_5001, 32'h1234_565A, 0, 32'h0,
            1'b0, 32'h0, 4'b0100, 32'h005A_0000, 1);
    run_req("byte_load0", 1'b0, 2'b00, 32'h0000_5000, 32'h0, 2, 32'h9A22_3344,
            1'b0, 32'h0000_009A, 4'b1000, 32'h0, 3);
    run_req("mis_word", 1'b0, 2'b10, 32'h0000_4001, 32'h0, 0, 32'h0,
            1'b1, 32'h0, 4'b0000, 32'h0, 0);
    run_req("mis_half", 1'b0, 2'b01, 32'h0000_4003, 32'h0, 0, 32'h0,
            1'b1, 32'h0, 4'b0000, 32'h0, 0);
    run_req("mis_size3", 1'b1, 2'b11, 32'h0000_4000, 32'h0, 0, 32'h0,
            1'b1, 32'h0, 4'b0000, 32'h0, 0);
    run_req("timeout", 1'b0, 2'b10, 32'h0000_7000, 32'h0, -1, 32'h0,
            1'b1, 32'h0, 4'b1111, 32'h0, 4);

    // Reset in the second wait cycle of a load: no response may follow.
    drive_req(1'b0, 2'b10, 32'h0000_6000, 32'h0);
    chk("rstmid_cyc_on", {31'h0, bus.wb_D_cyc_o}, 32'h1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rstmid_cyc_off", {31'h0, bus.wb_D_cyc_o}, 32'h0);
    chk("rstmid_ready", {31'h0, bus.req_ready_o}, 32'h1);
    chk("rstmid_no_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
    @(posedge clk_i);
    #1;
    chk("rstmid_no_rsp_late", {31'h0, bus.rsp_valid_o}, 32'h0);

    run_req("post_rst_load", 1'b0, 2'b10, 32'h0000_0000, 32'h0, 0, 32'hCAFE_F00D,
            1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0, 1);

    chk("sb_drained", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
